// File: rtl/mux_arb_pkg.sv
// Shared types and the rotating-priority helper for the round-robin mux arbiter.
package mux_arb_pkg;

   typedef enum logic {IDLE = 1'b0, OWN = 1'b1} arb_state_e;

   localparam int ARB_N_DEFAULT = 8;
   localparam int PICK_MAX      = 8;

   typedef struct packed {
      logic       valid;
      logic [2:0] idx;
   } pick_t;

   // First set request scanning ptr, ptr+1, ... modulo n (n <= PICK_MAX).
   function automatic pick_t rr_pick(input logic [7:0] req, input logic [2:0] ptr,
                                     input int unsigned n);
      pick_t      p;
      logic [2:0] k;
      p = '0;
      for (int unsigned i = 0; i < PICK_MAX; i++) begin
         if (i < n && !p.valid) begin
            k = 3'((32'(ptr) + i) % n);
            if (req[k]) begin
               p.valid = 1'b1;
               p.idx   = k;
            end
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Request/grant bundle between requesters and the arbiter driving the shared mux select.
interface mux_rr_arbiter_if #(parameter int N = 8);
   localparam int SEL_W = $clog2(N);

   logic [N-1:0]     req;
   logic [N-1:0]     gnt;
   logic             gnt_valid;
   logic [SEL_W-1:0] sel;
   logic             timeout;

   modport master (input req, output gnt, gnt_valid, sel, timeout);
   modport slave  (output req, input gnt, gnt_valid, sel, timeout);
endinterface

// File: rtl/rr_priority_pick.sv
// Combinational rotating priority encoder: lowest request at or after ptr, modulo N.
module rr_priority_pick
   import mux_arb_pkg::*;
#(
   parameter int N     = ARB_N_DEFAULT,
   parameter int SEL_W = $clog2(N)
) (
   input  logic [N-1:0]     i_req,
   input  logic [SEL_W-1:0] i_ptr,
   output logic [SEL_W-1:0] o_idx,
   output logic             o_any
);

   logic [7:0] w_req8;
   logic [2:0] w_ptr8;
   pick_t      w_pick;

   assign w_req8 = 8'(i_req);
   assign w_ptr8 = 3'(i_ptr);
   assign w_pick = rr_pick(w_req8, w_ptr8, N);
   assign o_idx  = SEL_W'(w_pick.idx);
   assign o_any  = w_pick.valid;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the shared 8:1 mux select; grants hold until the owner drops req.
// Optional forced release after MAX_HOLD owned cycles when ARB_TIMEOUT_EN is defined.
module mux_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int N        = ARB_N_DEFAULT,
   parameter int MAX_HOLD = 16
) (
   input  logic             clk,
   input  logic             reset,
   mux_rr_arbiter_if.master bus
);

   localparam int SEL_W = $clog2(N);

   if (N < 2 || N > 8 || (N & (N - 1)) != 0 || MAX_HOLD < 2) begin : g_bad_cfg
      $error("mux_rr_arbiter: N must be a power of 2 in 2..8 and MAX_HOLD >= 2");
   end

   arb_state_e       r_state, w_state_nxt;
   logic [N-1:0]     r_gnt;
   logic [SEL_W-1:0] r_sel;
   logic [SEL_W-1:0] r_ptr;

   logic [SEL_W-1:0] w_scan_ptr;
   logic [SEL_W-1:0] w_pick_idx;
   logic             w_pick_any;
   logic             w_release;
   logic             w_load;
   logic             w_clear;
   logic             w_force;

   // While owning, scan from the slot after the owner so the owner is considered last.
   rr_priority_pick #(.N(N), .SEL_W(SEL_W)) u_pick (
      .i_req (bus.req),
      .i_ptr (w_scan_ptr),
      .o_idx (w_pick_idx),
      .o_any (w_pick_any)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_pick_any) w_state_nxt = OWN;
         OWN:     if (w_release && !w_pick_any) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_scan_ptr = (r_state == OWN) ? r_sel + SEL_W'(1) : r_ptr;
      w_release  = (r_state == OWN) && (!bus.req[r_sel] || w_force);
      w_load     = w_pick_any && ((r_state == IDLE) || w_release);
      w_clear    = w_release && !w_pick_any;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_gnt <= '0;
         r_sel <= '0;
         r_ptr <= '0;
      end else begin
         if (w_load) begin
            r_gnt <= {{(N-1){1'b0}}, 1'b1} << w_pick_idx;
            r_sel <= w_pick_idx;
         end else if (w_clear) begin
            r_gnt <= '0;
         end
         if (w_release) r_ptr <= r_sel + SEL_W'(1);
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int HOLD_W = $clog2(MAX_HOLD) + 1;

   logic [HOLD_W-1:0] r_hold;
   logic              r_timeout;

   // Count reaches MAX_HOLD-1 after MAX_HOLD-1 owned edges; the next edge is the forced one.
   assign w_force = (r_state == OWN) && bus.req[r_sel] && (r_hold == HOLD_W'(MAX_HOLD - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hold    <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_force;
         if (w_load)              r_hold <= '0;
         else if (r_state == OWN) r_hold <= r_hold + HOLD_W'(1);
      end
   end

   assign bus.timeout = r_timeout;
`else
   assign w_force     = 1'b0;
   assign bus.timeout = 1'b0;
`endif

   assign bus.gnt       = r_gnt;
   assign bus.gnt_valid = |r_gnt;
   assign bus.sel       = r_sel;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: reset, rotation, hold, idle sel, mid-grant reset, timeout.
module tb_mux_rr_arbiter;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   mux_rr_arbiter_if #(.N(8)) bus ();

   mux_rr_arbiter #(.N(8), .MAX_HOLD(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      bus.req = 8'h00;
      tick();
      reset   = 1'b0;
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      bus.req = 8'hFF;
      tick();
      tick();
      n_checks++;
      if (bus.gnt !== 8'h00) begin n_fail++; $display("FAIL reset_gnt got %h want 00", bus.gnt); end
      n_checks++;
      if (bus.sel !== 3'd0) begin n_fail++; $display("FAIL reset_sel got %0d want 0", bus.sel); end
      n_checks++;
      if (bus.gnt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.gnt_valid); end
      n_checks++;
      if (bus.timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %b want 0", bus.timeout); end
      reset = 1'b0;
      tick();
      n_checks++;
      if (bus.gnt !== 8'h01 || bus.sel !== 3'd0 || bus.gnt_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL first_grant got gnt=%h sel=%0d v=%b want gnt=01 sel=0 v=1", bus.gnt, bus.sel, bus.gnt_valid);
      end
   endtask

   // Continues from test_reset: owner 0 holds with all requests high.
   task automatic test_round_robin();
      int         o;
      logic [7:0] exp;
      o = 0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         exp = 8'h01 << o;
         n_checks++;
         if (bus.gnt !== exp) begin n_fail++; $display("FAIL rr_hold_%0d got %h want %h", k, bus.gnt, exp); end
         bus.req    = 8'hFF;
         bus.req[o] = 1'b0;
         tick();
         bus.req = 8'hFF;
         o       = (o + 1) % 8;
         exp     = 8'h01 << o;
         n_checks++;
         if (bus.gnt !== exp || bus.sel !== 3'(o) || bus.gnt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rr_next_%0d got gnt=%h sel=%0d v=%b want gnt=%h sel=%0d v=1",
                     k, bus.gnt, bus.sel, bus.gnt_valid, exp, o);
         end
      end
   endtask

   task automatic test_hold();
      do_reset();
      bus.req = 8'h08;
      tick();
      n_checks++;
      if (bus.gnt !== 8'h08) begin n_fail++; $display("FAIL hold_grant got %h want 08", bus.gnt); end
      bus.req = 8'h09;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_checks++;
         if (bus.gnt !== 8'h08 || bus.sel !== 3'd3) begin
            n_fail++;
            $display("FAIL hold_nopreempt_%0d got gnt=%h sel=%0d want gnt=08 sel=3", k, bus.gnt, bus.sel);
         end
      end
      bus.req = 8'h01;
      tick();
      n_checks++;
      if (bus.gnt !== 8'h01 || bus.sel !== 3'd0) begin
         n_fail++;
         $display("FAIL hold_handover got gnt=%h sel=%0d want gnt=01 sel=0", bus.gnt, bus.sel);
      end
   endtask

   task automatic test_idle_sel();
      do_reset();
      bus.req = 8'h20;
      tick();
      n_checks++;
      if (bus.gnt !== 8'h20 || bus.sel !== 3'd5) begin
         n_fail++;
         $display("FAIL idle_grant5 got gnt=%h sel=%0d want gnt=20 sel=5", bus.gnt, bus.sel);
      end
      bus.req = 8'h00;
      for (int k = 0; k < 2; k++) begin
         tick();
         n_checks++;
         if (bus.gnt !== 8'h00 || bus.gnt_valid !== 1'b0 || bus.sel !== 3'd5) begin
            n_fail++;
            $display("FAIL idle_sel_%0d got gnt=%h v=%b sel=%0d want gnt=00 v=0 sel=5",
                     k, bus.gnt, bus.gnt_valid, bus.sel);
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.req = 8'h40;
      tick();
      n_checks++;
      if (bus.gnt !== 8'h40 || bus.sel !== 3'd6) begin
         n_fail++;
         $display("FAIL mid_grant6 got gnt=%h sel=%0d want gnt=40 sel=6", bus.gnt, bus.sel);
      end
      reset   = 1'b1;
      bus.req = 8'h44;
      tick();
      reset = 1'b0;
      n_checks++;
      if (bus.gnt !== 8'h00 || bus.gnt_valid !== 1'b0 || bus.sel !== 3'd0) begin
         n_fail++;
         $display("FAIL mid_reset got gnt=%h v=%b sel=%0d want gnt=00 v=0 sel=0", bus.gnt, bus.gnt_valid, bus.sel);
      end
      tick();
      n_checks++;
      if (bus.gnt !== 8'h04 || bus.sel !== 3'd2) begin
         n_fail++;
         $display("FAIL mid_regrant got gnt=%h sel=%0d want gnt=04 sel=2", bus.gnt, bus.sel);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      bus.req = 8'h81;
      tick();
      n_checks++;
      if (bus.gnt !== 8'h01) begin n_fail++; $display("FAIL b2b_first got %h want 01", bus.gnt); end
      bus.req = 8'h80;
      tick();
      n_checks++;
      if (bus.gnt !== 8'h80 || bus.sel !== 3'd7) begin
         n_fail++;
         $display("FAIL b2b_seven got gnt=%h sel=%0d want gnt=80 sel=7", bus.gnt, bus.sel);
      end
      bus.req = 8'h01;
      tick();
      n_checks++;
      if (bus.gnt !== 8'h01 || bus.sel !== 3'd0) begin
         n_fail++;
         $display("FAIL b2b_wrap got gnt=%h sel=%0d want gnt=01 sel=0", bus.gnt, bus.sel);
      end
   endtask

`ifdef ARB_TIMEOUT_EN
   task automatic test_timeout();
      logic [7:0] exp_g [0:8];
      logic       exp_t [0:8];
      exp_g = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h02, 8'h02, 8'h01};
      exp_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      do_reset();
      bus.req = 8'h03;
      for (int k = 0; k < 9; k++) begin
         tick();
         n_checks++;
         if (bus.gnt !== exp_g[k] || bus.timeout !== exp_t[k]) begin
            n_fail++;
            $display("FAIL timeout_%0d got gnt=%h to=%b want gnt=%h to=%b",
                     k, bus.gnt, bus.timeout, exp_g[k], exp_t[k]);
         end
      end
   endtask
`else
   task automatic test_timeout();
      do_reset();
      bus.req = 8'h03;
      for (int k = 0; k < 12; k++) begin
         tick();
         n_checks++;
         if (bus.gnt !== 8'h01 || bus.timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL unbounded_%0d got gnt=%h to=%b want gnt=01 to=0", k, bus.gnt, bus.timeout);
         end
      end
   endtask
`endif

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      bus.req  = 8'h00;
      test_reset();
      test_round_robin();
      test_hold();
      test_idle_sel();
      test_reset_mid();
      test_back_to_back();
      test_timeout();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
